ram_wr_ctrl: RTL and testbench
==============================

Name: ram_wr_ctrl

Overview:
Write-port front end for the 32x4 dual-port RAM. It turns raw board controls (write-enable switch, address/data switches, active-low push-buttons) into clean, single-cycle RAM write transactions on wraddress/data/wren. It also provides a clear sweep that fills every RAM location with a constant. It sits directly upstream of the RAM write port, in the same clock domain as the RAM.

Parameters:
ADDR_W, 5, RAM address width
DATA_W, 4, RAM data width
DEPTH, 32, number of locations written by a clear sweep (2**ADDR_W)
CLEAR_VAL, 0, data value written during a clear sweep
DB_CYCLES, 250000, debounce stability window in clk cycles (used only with DEBOUNCE_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
we_sw  input  1  write-enable switch level
addr_sw  input  ADDR_W  requested write address (switches)
data_sw  input  DATA_W  requested write data (switches)
commit_n  input  1  raw commit push-button, active-low, asynchronous to clk
clear_n  input  1  raw clear push-button, active-low, asynchronous to clk
wraddress  output  ADDR_W  RAM write address
data  output  DATA_W  RAM write data
wren  output  1  RAM write enable, registered
busy  output  1  high while a write or clear sweep is in progress
wr_count  output  8  number of completed single writes, wraps modulo 256

Behaviour:
- Reset (reset=0) asynchronously forces the following:
  - state=IDLE
  - wraddress=0, data=0, wren=0, busy=0, wr_count=0
  - both button synchronizer chains preset to 1 (released), so no event fires on reset release.
- commit_n and clear_n each pass through a 2-flop synchronizer. A press event is a 1-cycle pulse on the synchronized level going 1->0.
- A held button yields exactly one event; the next event requires a release then a new press.
- we_sw, addr_sw and data_sw are sampled on the same edge that the FSM acts on the event. These switches are quasi-static and are not synchronized.
- Latency: commit_n first sampled low at edge k -> wren high from edge k+3 to k+4.
- FSM states:
  - IDLE:
    - clear event -> CLEAR. Load wraddress=0, data=CLEAR_VAL, set wren=1, busy=1.
    - else commit event with we_sw=1 -> WRITE. Load wraddress=addr_sw, data=data_sw, set wren=1, busy=1.
    - commit event with we_sw=0 is ignored.
  - WRITE: lasts exactly one cycle, then -> IDLE with wren=0, busy=0, wr_count+1.
  - CLEAR:
    - wren stays 1 for DEPTH consecutive cycles while wraddress steps 0,1,...,DEPTH-1.
    - After the cycle with wraddress=DEPTH-1: -> IDLE, wren=0, busy=0, wraddress left at DEPTH-1.
    - A clear sweep does not change wr_count.
- Simultaneous commit and clear events in IDLE: clear wins; the commit is discarded.
- Events arriving in WRITE or CLEAR are dropped, not queued.
- In IDLE, wraddress and data hold their last driven values; wren=0.
- Reset asserted mid-sweep aborts immediately with all outputs at reset values. There is no resume after reset release.
- wr_count rolls over 255->0.

Optional Feature:
DEBOUNCE_EN
- Defined: each synchronized button feeds a debouncer. The debounced level updates only after the synchronized level has differed from it for DB_CYCLES consecutive cycles; any bounce restarts the count. Press events are detected on the debounced level. Commit-to-wren latency becomes DB_CYCLES+3 edges. Debounced levels reset to 1.
- Undefined: no debouncer; events are detected directly on the synchronizer outputs, with the 3-edge latency above.

Test Plan:
1. Release reset; we_sw=1, addr_sw=5, data_sw=0xA; pulse commit_n low for 4 cycles -> exactly one wren cycle with wraddress=5, data=0xA, 3 edges after press; busy high for that cycle; wr_count=1.
2. we_sw=0, addr_sw=9; press commit -> wren stays 0; wr_count unchanged; wraddress/data hold 5/0xA.
3. we_sw=1; hold commit_n low for 100 cycles then release -> exactly one wren pulse; wr_count+1.
4. Press clear_n -> 32 consecutive wren cycles, wraddress 0..31, data=0 (CLEAR_VAL); busy high for 32 cycles. A commit pressed at sweep cycle 10 is dropped, and wr_count is unchanged.
5. Assert commit_n and clear_n on the same cycle -> clear sweep only; no single write; wr_count unchanged.
6. Start a clear sweep; drive reset=0 when wraddress=10 -> wren, busy, wraddress and wr_count go to 0 immediately without a clock edge. After reset release, outputs stay idle with no spurious event.
(With DEBOUNCE_EN, DB_CYCLES=8: a 3-cycle glitch on commit_n produces no write; a 20-cycle press produces one write, 11 edges after the press.)

Source files
------------

// File: rtl/ram_wr_ctrl.sv
// ram_wr_ctrl -- write-port front end for a 2**ADDR_W x DATA_W dual-port RAM.
//
// Turns board controls into clean single-cycle RAM write transactions.
// It also provides a clear sweep that fills every RAM location with CLEAR_VAL.
// It lives in the RAM's clock domain.
//
// Build option:
//   DEBOUNCE_EN  When defined, each synchronized push-button passes through a
//                DB_CYCLES-cycle debouncer before edge detection. This adds
//                DB_CYCLES edges to the commit-to-wren latency.
//                When undefined, edges are detected straight off the
//                synchronizers: commit sampled low at edge k gives wren at
//                edge k+3.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   we_sw      write-enable switch (quasi-static, not synchronized)
//   addr_sw    requested write address (quasi-static)
//   data_sw    requested write data (quasi-static)
//   commit_n   raw commit push-button, active-low, asynchronous
//   clear_n    raw clear push-button, active-low, asynchronous
//   wraddress  RAM write address (registered)
//   data       RAM write data (registered)
//   wren       RAM write enable (registered)
//   busy       high while a single write or a clear sweep is in progress
//   wr_count   completed single writes, wraps modulo 256

module ram_wr_ctrl #(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 4,
   parameter int DEPTH     = 32,
   parameter int CLEAR_VAL = 0,
   parameter int DB_CYCLES = 250000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we_sw,
   input  logic [ADDR_W-1:0] addr_sw,
   input  logic [DATA_W-1:0] data_sw,
   input  logic              commit_n,
   input  logic              clear_n,
   output logic [ADDR_W-1:0] wraddress,
   output logic [DATA_W-1:0] data,
   output logic              wren,
   output logic              busy,
   output logic [7:0]        wr_count
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [DATA_W-1:0] CLR_DATA  = DATA_W'(CLEAR_VAL);

   // Elaboration-time parameter sanity checks.
   if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
      $error("ram_wr_ctrl: DEPTH must equal 2**ADDR_W");
   end
   if (DB_CYCLES < 1) begin : g_bad_db
      $error("ram_wr_ctrl: DB_CYCLES must be at least 1");
   end

`ifdef DEBOUNCE_EN
   localparam int CNT_W = $clog2(DB_CYCLES + 1);
`endif

   // ------------------------------------------------------------------
   // Button conditioning: bit 0 = commit, bit 1 = clear
   // ------------------------------------------------------------------
   logic [1:0] btn_n;
   logic [1:0] btn_evt;

   assign btn_n = {clear_n, commit_n};

   for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic sync1_reg;
      logic sync2_reg;
      logic btn_level;
      logic level_prev_reg;
      logic evt_reg;

      // Chain presets to "released" so that reset release never looks
      // like a press.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
         end else begin
            sync1_reg <= btn_n[gi];
            sync2_reg <= sync1_reg;
         end
      end

`ifdef DEBOUNCE_EN
      logic             db_reg;
      logic [CNT_W-1:0] db_cnt_reg;

      // The debounced level follows the synchronized level only after
      // DB_CYCLES consecutive cycles of disagreement. Any agreement
      // (bounce) restarts the count.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            db_reg     <= 1'b1;
            db_cnt_reg <= '0;
         end else if (sync2_reg == db_reg) begin
            db_cnt_reg <= '0;
         end else if (db_cnt_reg == CNT_W'(DB_CYCLES - 1)) begin
            db_reg     <= sync2_reg;
            db_cnt_reg <= '0;
         end else begin
            db_cnt_reg <= db_cnt_reg + CNT_W'(1);
         end
      end

      assign btn_level = db_reg;
`else
      assign btn_level = sync2_reg;
`endif

      // The falling-edge pulse is registered. This gives the FSM a clean
      // flop-driven event and sets the overall 3-edge press-to-wren latency.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            level_prev_reg <= 1'b1;
            evt_reg        <= 1'b0;
         end else begin
            level_prev_reg <= btn_level;
            evt_reg        <= level_prev_reg & ~btn_level;
         end
      end

      assign btn_evt[gi] = evt_reg;
   end

   logic commit_evt;
   logic clear_evt;

   assign commit_evt = btn_evt[0];
   assign clear_evt  = btn_evt[1];

   // ------------------------------------------------------------------
   // Write FSM
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      CLEAR = 2'd2
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic [ADDR_W-1:0] wraddress_reg;
   logic [ADDR_W-1:0] wraddress_next;
   logic [DATA_W-1:0] data_reg;
   logic [DATA_W-1:0] data_next;
   logic              wren_reg;
   logic              wren_next;
   logic              busy_reg;
   logic              busy_next;
   logic [7:0]        wr_count_reg;
   logic [7:0]        wr_count_next;

   // State and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg     <= IDLE;
         wraddress_reg <= '0;
         data_reg      <= '0;
         wren_reg      <= 1'b0;
         busy_reg      <= 1'b0;
         wr_count_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         wraddress_reg <= wraddress_next;
         data_reg      <= data_next;
         wren_reg      <= wren_next;
         busy_reg      <= busy_next;
         wr_count_reg  <= wr_count_next;
      end
   end

   // Next state. Events that arrive outside IDLE are single-cycle pulses.
   // They are simply not looked at, so they are dropped rather than queued.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (clear_evt) begin
               state_next = CLEAR;
            end else if (commit_evt && we_sw) begin
               state_next = WRITE;
            end
         end
         WRITE: state_next = IDLE;
         CLEAR: begin
            if (wraddress_reg == LAST_ADDR) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      wraddress_next = wraddress_reg;
      data_next      = data_reg;
      wren_next      = 1'b0;
      busy_next      = 1'b0;
      wr_count_next  = wr_count_reg;
      case (state_reg)
         IDLE: begin
            if (clear_evt) begin
               wraddress_next = '0;
               data_next      = CLR_DATA;
               wren_next      = 1'b1;
               busy_next      = 1'b1;
            end else if (commit_evt && we_sw) begin
               wraddress_next = addr_sw;
               data_next      = data_sw;
               wren_next      = 1'b1;
               busy_next      = 1'b1;
            end
         end
         WRITE: begin
            wr_count_next = wr_count_reg + 8'd1;
         end
         CLEAR: begin
            // On the last location the address is left parked at LAST_ADDR.
            if (wraddress_reg != LAST_ADDR) begin
               wraddress_next = wraddress_reg + ADDR_W'(1);
               wren_next      = 1'b1;
               busy_next      = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign wraddress = wraddress_reg;
   assign data      = data_reg;
   assign wren      = wren_reg;
   assign busy      = busy_reg;
   assign wr_count  = wr_count_reg;

endmodule

// File: tb/tb_ram_wr_ctrl.sv
`timescale 1ns/1ps
module tb_ram_wr_ctrl;

   localparam int ADDR_W    = 5;
   localparam int DATA_W    = 4;
   localparam int DEPTH     = 32;
   localparam int CLEAR_VAL = 0;
`ifdef DEBOUNCE_EN
   localparam int DB     = 8;
   localparam int LAT    = DB + 4;   // drive cycle c -> wren at edge c+1+DB+3
   localparam int MINLEN = DB + 4;
`else
   localparam int DB     = 1;
   localparam int LAT    = 4;        // drive cycle c -> wren at edge c+1+3
   localparam int MINLEN = 1;
`endif

   logic              clk;
   logic              reset;
   logic              we_sw;
   logic [ADDR_W-1:0] addr_sw;
   logic [DATA_W-1:0] data_sw;
   logic              commit_n;
   logic              clear_n;
   logic [ADDR_W-1:0] wraddress;
   logic [DATA_W-1:0] data;
   logic              wren;
   logic              busy;
   logic [7:0]        wr_count;

   ram_wr_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
      .CLEAR_VAL(CLEAR_VAL), .DB_CYCLES(DB)
   ) dut (
      .clk(clk), .reset(reset), .we_sw(we_sw), .addr_sw(addr_sw),
      .data_sw(data_sw), .commit_n(commit_n), .clear_n(clear_n),
      .wraddress(wraddress), .data(data), .wren(wren), .busy(busy),
      .wr_count(wr_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Expected RAM write transactions, each tagged with the cycle it must appear in
   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      int                cyc;
   } wr_t;
   wr_t q[$];

   int  n_cmp = 0;
   int  n_bad = 0;
   bit  mon_en = 1'b0;
   bit  exp_w;
   int  exp_cnt = 0;
   int  last_addr = 0;
   int  last_data = 0;
   int  press_cyc = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Monitor: every cycle, compare wren/busy against whether the scoreboard
   // expects a write now; on a write, pop and compare address and data.
   always @(negedge clk) begin
      if (mon_en) begin
         exp_w = (q.size() > 0) && (q[0].cyc == cyc);
         chk("wren", 32'(wren), 32'(exp_w));
         chk("busy", 32'(busy), 32'(exp_w));
         if (exp_w) begin
            chk("wraddress", 32'(wraddress), 32'(q[0].addr));
            chk("data", 32'(data), 32'(q[0].data));
            $display("write cyc=%0d addr=%0d data=%0h", cyc, wraddress, data);
            void'(q.pop_front());
         end else if (q.size() > 0 && q[0].cyc < cyc) begin
            void'(q.pop_front());   // missed write, already reported by the wren check
         end
      end
   end

   task automatic set_sw(bit we, int a, int d);
      we_sw   = we;
      addr_sw = ADDR_W'(a);
      data_sw = DATA_W'(d);
   endtask

   // Press buttons for len cycles and record what the RAM should see.
   task automatic press(bit do_commit, bit do_clear, int len);
      wr_t e;
      @(posedge clk); #1;
      press_cyc = cyc;
      if (do_commit) commit_n = 1'b0;
      if (do_clear)  clear_n  = 1'b0;
      if (do_clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            e.addr = ADDR_W'(i);
            e.data = DATA_W'(CLEAR_VAL);
            e.cyc  = press_cyc + LAT + i;
            q.push_back(e);
         end
         last_addr = DEPTH - 1;
         last_data = CLEAR_VAL;
      end else if (do_commit && we_sw) begin
         e.addr = addr_sw;
         e.data = data_sw;
         e.cyc  = press_cyc + LAT;
         q.push_back(e);
         exp_cnt   = (exp_cnt + 1) % 256;
         last_addr = int'(addr_sw);
         last_data = int'(data_sw);
      end
      repeat (len) @(posedge clk);
      #1;
      commit_n = 1'b1;
      clear_n  = 1'b1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (q.size() > 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
      repeat (DB + 8) @(posedge clk);
      #1;
   endtask

   task automatic check_idle(string tag);
      chk({tag, "_wr_count"}, 32'(wr_count), 32'(exp_cnt));
      chk({tag, "_addr_hold"}, 32'(wraddress), 32'(last_addr));
      chk({tag, "_data_hold"}, 32'(data), 32'(last_data));
      chk({tag, "_wren_idle"}, 32'(wren), 32'd0);
      $display("idle %s: wr_count=%0d addr=%0d data=%0h", tag, wr_count, wraddress, data);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int len;
      int r;
      reset    = 1'b0;
      commit_n = 1'b1;
      clear_n  = 1'b1;
      set_sw(0, 0, 0);
      #12;
      chk("rst_wraddress", 32'(wraddress), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_wren", 32'(wren), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_count", 32'(wr_count), 32'd0);
      #11 reset = 1'b1;
      mon_en = 1'b1;
      repeat (5) @(posedge clk);

      // 1: basic single write
      set_sw(1, 5, 4'hA);
      press(1, 0, 4);
      wait_idle();
      check_idle("t1");

      // 2: commit with write disabled is ignored
      set_sw(0, 9, 3);
      press(1, 0, 4);
      wait_idle();
      check_idle("t2");

      // 3: long hold gives a single write
      set_sw(1, 17, 6);
      press(1, 0, 100);
      wait_idle();
      check_idle("t3");

      // 4: clear sweep, commit pressed mid-sweep is dropped
      set_sw(1, 3, 12);
      press(0, 1, 3);
      repeat (press_cyc + LAT + 10 - cyc) @(posedge clk);
      #1 commit_n = 1'b0;
      repeat (MINLEN + 2) @(posedge clk);
      #1 commit_n = 1'b1;
      wait_idle();
      check_idle("t4");

      // 5: simultaneous commit and clear -> clear only
      set_sw(1, 22, 9);
      press(1, 1, 4);
      wait_idle();
      check_idle("t5");

`ifdef DEBOUNCE_EN
      // Glitch shorter than the debounce window produces nothing
      set_sw(1, 11, 5);
      @(posedge clk); #1 commit_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 commit_n = 1'b1;
      wait_idle();
      check_idle("glitch");
      set_sw(1, 12, 7);
      press(1, 0, 20);
      wait_idle();
      check_idle("db_press");
`endif

      // Randomized single writes, ignored commits, clears and simultaneous presses
      for (int it = 0; it < 30; it++) begin
         r   = int'($urandom_range(0, 9));
         len = int'($urandom_range(MINLEN, MINLEN + 15));
         set_sw($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)),
                int'($urandom_range(0, 15)));
         if (r == 0)      press(0, 1, len);
         else if (r == 1) press(1, 1, len);
         else             press(1, 0, len);
         wait_idle();
         check_idle("rnd");
      end

      // 6: reset in the middle of a sweep
      set_sw(1, 4, 4);
      press(0, 1, 2);
      repeat (press_cyc + LAT + 10 - cyc) @(posedge clk);
      #2;
      chk("t6_pre_addr", 32'(wraddress), 32'd10);
      mon_en = 1'b0;
      reset  = 1'b0;
      #1;
      chk("t6_wren", 32'(wren), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_wraddress", 32'(wraddress), 32'd0);
      chk("t6_data", 32'(data), 32'd0);
      chk("t6_wr_count", 32'(wr_count), 32'd0);
      q.delete();
      exp_cnt   = 0;
      last_addr = 0;
      last_data = 0;
      @(posedge clk);
      #3 reset = 1'b1;
      mon_en = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check_idle("t6_post");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
